mmu_req_agent: RTL and testbench
================================

Name: mmu_req_agent

Overview:
- Host-side requester for the MMU allocator: the other end of the request/response FIFO interface that the MMU core pops and writes.
- Accepts host alloc/free commands over valid/ready, assigns request IDs and pushes requests into the alloc/free request FIFOs.
- Pops the alloc/free response FIFOs, checks each response ID against an outstanding-ID tracker, and returns responses to the host over valid/ready.

Parameters:
- ID_W, `REQ_ID_WIDTH (8): request ID width; ID space is 2^ID_W.
- SIZE_W, `REQ_SIZE_TYPE_WIDTH: page-count field width.
- PIDX_W, `ALL_PAGE_IDX_WIDTH: page index width.
- FR_W, `FAIL_REASON_WIDTH: fail reason width.
- MAX_OUTST, 64: maximum outstanding requests; must be ≤ 2^ID_W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- host_alloc_valid / host_alloc_ready  in / out  1  alloc command handshake
- host_alloc_page_count  in  SIZE_W  requested pages
- host_free_valid / host_free_ready  in / out  1  free command handshake
- host_free_page_idx  in  PIDX_W  first page to free
- host_free_page_count  in  SIZE_W  pages to free
- alloc_req_push  out  1  alloc request FIFO write
- alloc_req_id  out  ID_W  request ID
- alloc_req_page_count  out  SIZE_W  request size
- alloc_req_fifo_almost_full  in  1  at least one free slot remains while asserted
- free_req_push  out  1  free request FIFO write
- free_req_id  out  ID_W  request ID
- free_req_page_idx  out  PIDX_W  page index
- free_req_page_count  out  SIZE_W  request size
- free_req_fifo_almost_full  in  1  at least one free slot remains while asserted
- alloc_rsp_pop  out  1  alloc response FIFO pop (FWFT)
- alloc_rsp_fifo_empty  in  1  alloc response FIFO empty
- alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason, alloc_rsp_origin_size, alloc_rsp_actual_size  in  ID_W, PIDX_W, 1, FR_W, SIZE_W, SIZE_W  alloc response head word
- free_rsp_pop  out  1  free response FIFO pop (FWFT)
- free_rsp_fifo_empty  in  1  free response FIFO empty
- free_rsp_id, free_rsp_fail, free_rsp_fail_reason, free_rsp_origin_size, free_rsp_actual_size  in  ID_W, 1, FR_W, SIZE_W, SIZE_W  free response head word
- host_alloc_rsp_valid / host_alloc_rsp_ready  out / in  1  alloc response handshake
- host_alloc_rsp_{id,page_idx,fail,fail_reason,origin_size,actual_size}  out  as above  registered alloc response
- host_free_rsp_valid / host_free_rsp_ready  out / in  1  free response handshake
- host_free_rsp_{id,fail,fail_reason,origin_size,actual_size}  out  as above  registered free response
- outstanding_count  out  clog2(MAX_OUTST+1)  current outstanding requests
- err_unexpected_rsp  out  1  sticky protocol error flag

Behaviour:
- Reset: all outputs 0, next_id = 0, tracker clear, round-robin pointer favours alloc. Reset mid-operation discards in-flight registers and tracked IDs.
- Issue arbitration: at most one command per cycle. When both host valids are high, round-robin picks; the pointer toggles only on an accepted issue.
- Readiness: a channel's ready is high only when all of the following hold, and the ready is combinational:
  - the channel holds the grant;
  - its request FIFO almost_full is low;
  - tracker bit [next_id] is clear;
  - outstanding_count < MAX_OUTST.
- Issue timing: a handshake in cycle N produces a one-cycle push in N+1 with registered fields and ID = next_id.
- Tracker update on issue: next_id increments, wrapping 2^ID_W-1 → 0. Tracker sets busy[next_id] and type[next_id] (1 = alloc).
- ID collision: if busy[next_id] is set, issue stalls until that ID retires; IDs are never skipped.
- Response path, per channel, with an independent output register:
  - pop = !empty && (!out_valid || out_ready);
  - the same cycle loads the head word and sets out_valid;
  - out_valid clears on host ready when no new pop occurs.
  - Throughput is one response per cycle per channel; latency is one cycle from FIFO head to host.
- Retire check: on a pop with busy[id] set and a matching type, clear busy[id] and decrement the count.
- Unexpected response: busy clear or type mismatch sets err_unexpected_rsp, which holds until rst. The response is still forwarded; the tracker and count are unchanged.
- Simultaneous events: issue set, alloc retire and free retire can occur in the same cycle.
  - They always hit distinct bits, since the issued bit is clear.
  - count_next = count + issue − alloc_retire − free_retire.
- fail=1 responses retire their ID like successes.

Decomposition:
- Shared define header (existing): REQ_ID_WIDTH, REQ_SIZE_TYPE_WIDTH, ALL_PAGE_IDX_WIDTH, FAIL_REASON_WIDTH. Add MMU_MAX_OUTSTANDING.
- Sub-module mmu_id_tracker:
  - holds the busy/type bitmaps and outstanding counter;
  - has one set port and two check/clear ports;
  - outputs id_free, hit flags and count.

Test Plan:
- Single alloc page_count=4 after reset → alloc_req_push one cycle after handshake with id=0. Inject rsp id=0, page_idx=16 → host_alloc_rsp valid next cycle, outstanding 1→0, no error.
- Alloc and free held valid together for 4 cycles → issues alternate A,F,A,F with ids 0,1,2,3; each channel's push count = 2.
- alloc_req_fifo_almost_full=1 → host_alloc_ready=0 and no push; deassert → issue resumes the next cycle.
- 64 allocs without responses → 65th stalls with outstanding_count=64. Respond id=5 → ready returns.
- Free response with id=9 never issued → err_unexpected_rsp=1 and is forwarded, count unchanged. Alloc rsp for a free-issued id also sets the error.
- Both rsp FIFOs non-empty with host_*_rsp_ready=0 → exactly one pop each, then hold; raising ready → one pop per cycle. Assert rst mid-burst → all outputs return to 0 and the count is 0.

Source files
------------

// File: rtl/mmu_req_agent_pkg.sv
// Shared widths, limits and arbitration encoding for the MMU request agent.
package mmu_req_agent_pkg;

   localparam int unsigned REQ_ID_WIDTH        = 8;
   localparam int unsigned REQ_SIZE_TYPE_WIDTH = 8;
   localparam int unsigned ALL_PAGE_IDX_WIDTH  = 10;
   localparam int unsigned FAIL_REASON_WIDTH   = 3;
   localparam int unsigned MMU_MAX_OUTSTANDING = 64;

   // Round-robin issue pointer: which channel wins when both host valids are high.
   typedef enum logic {
      RR_ALLOC = 1'b0,
      RR_FREE  = 1'b1
   } rr_e;

endpackage

// File: rtl/mmu_req_agent_id.sv
// Outstanding-ID tracker: busy/type bitmaps indexed by request ID plus a live count.
// One set port (issue) and two check/clear ports (alloc and free retire).
module mmu_id_tracker #(
   parameter int unsigned ID_W      = 8,
   parameter int unsigned MAX_OUTST = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             set_en,
   input  logic [ID_W-1:0]                  set_id,
   input  logic                             set_is_alloc,
   input  logic [ID_W-1:0]                  query_id,
   output logic                             id_free,
   input  logic                             alloc_chk_en,
   input  logic [ID_W-1:0]                  alloc_chk_id,
   output logic                             alloc_hit,
   input  logic                             free_chk_en,
   input  logic [ID_W-1:0]                  free_chk_id,
   output logic                             free_hit,
   output logic [$clog2(MAX_OUTST+1)-1:0]   count
);

   localparam int unsigned DEPTH = 1 << ID_W;
   localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [DEPTH-1:0] type_q, type_d;
   logic [CNT_W-1:0] count_q, count_d;

   assign id_free   = ~busy_q[query_id];
   assign alloc_hit = alloc_chk_en & busy_q[alloc_chk_id] & type_q[alloc_chk_id];
   assign free_hit  = free_chk_en & busy_q[free_chk_id] & ~type_q[free_chk_id];
   assign count     = count_q;

   // Set and the two clears always touch distinct bits: the issued bit is clear,
   // and a retire needs the bit busy with a type matching only one channel.
   always_comb begin
      busy_d = busy_q;
      type_d = type_q;
      if (set_en) begin
         busy_d[set_id] = 1'b1;
         type_d[set_id] = set_is_alloc;
      end
      if (alloc_hit) busy_d[alloc_chk_id] = 1'b0;
      if (free_hit)  busy_d[free_chk_id]  = 1'b0;
      count_d = count_q + CNT_W'(set_en) - CNT_W'(alloc_hit) - CNT_W'(free_hit);
   end

   // Tracker state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= '0;
         type_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         type_q  <= type_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mmu_req_agent.sv
// Host-side requester for the MMU allocator: issues alloc/free requests with
// tracked IDs and returns FIFO responses to the host through output registers.
module mmu_req_agent
   import mmu_req_agent_pkg::*;
#(
   parameter int unsigned ID_W      = REQ_ID_WIDTH,
   parameter int unsigned SIZE_W    = REQ_SIZE_TYPE_WIDTH,
   parameter int unsigned PIDX_W    = ALL_PAGE_IDX_WIDTH,
   parameter int unsigned FR_W      = FAIL_REASON_WIDTH,
   parameter int unsigned MAX_OUTST = MMU_MAX_OUTSTANDING
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           host_alloc_valid,
   output logic                           host_alloc_ready,
   input  logic [SIZE_W-1:0]              host_alloc_page_count,
   input  logic                           host_free_valid,
   output logic                           host_free_ready,
   input  logic [PIDX_W-1:0]              host_free_page_idx,
   input  logic [SIZE_W-1:0]              host_free_page_count,
   output logic                           alloc_req_push,
   output logic [ID_W-1:0]                alloc_req_id,
   output logic [SIZE_W-1:0]              alloc_req_page_count,
   input  logic                           alloc_req_fifo_almost_full,
   output logic                           free_req_push,
   output logic [ID_W-1:0]                free_req_id,
   output logic [PIDX_W-1:0]              free_req_page_idx,
   output logic [SIZE_W-1:0]              free_req_page_count,
   input  logic                           free_req_fifo_almost_full,
   output logic                           alloc_rsp_pop,
   input  logic                           alloc_rsp_fifo_empty,
   input  logic [ID_W-1:0]                alloc_rsp_id,
   input  logic [PIDX_W-1:0]              alloc_rsp_page_idx,
   input  logic                           alloc_rsp_fail,
   input  logic [FR_W-1:0]                alloc_rsp_fail_reason,
   input  logic [SIZE_W-1:0]              alloc_rsp_origin_size,
   input  logic [SIZE_W-1:0]              alloc_rsp_actual_size,
   output logic                           free_rsp_pop,
   input  logic                           free_rsp_fifo_empty,
   input  logic [ID_W-1:0]                free_rsp_id,
   input  logic                           free_rsp_fail,
   input  logic [FR_W-1:0]                free_rsp_fail_reason,
   input  logic [SIZE_W-1:0]              free_rsp_origin_size,
   input  logic [SIZE_W-1:0]              free_rsp_actual_size,
   output logic                           host_alloc_rsp_valid,
   input  logic                           host_alloc_rsp_ready,
   output logic [ID_W-1:0]                host_alloc_rsp_id,
   output logic [PIDX_W-1:0]              host_alloc_rsp_page_idx,
   output logic                           host_alloc_rsp_fail,
   output logic [FR_W-1:0]                host_alloc_rsp_fail_reason,
   output logic [SIZE_W-1:0]              host_alloc_rsp_origin_size,
   output logic [SIZE_W-1:0]              host_alloc_rsp_actual_size,
   output logic                           host_free_rsp_valid,
   input  logic                           host_free_rsp_ready,
   output logic [ID_W-1:0]                host_free_rsp_id,
   output logic                           host_free_rsp_fail,
   output logic [FR_W-1:0]                host_free_rsp_fail_reason,
   output logic [SIZE_W-1:0]              host_free_rsp_origin_size,
   output logic [SIZE_W-1:0]              host_free_rsp_actual_size,
   output logic [$clog2(MAX_OUTST+1)-1:0] outstanding_count,
   output logic                           err_unexpected_rsp
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

   rr_e              rr_q, rr_d;
   logic [ID_W-1:0]  next_id_q, next_id_d;
   logic             grant_alloc, grant_free;
   logic             can_issue, id_free;
   logic             alloc_fire, free_fire;
   logic             alloc_hit, free_hit;
   logic [CNT_W-1:0] count;

   logic              a_push_q, f_push_q;
   logic [ID_W-1:0]   a_id_q, f_id_q;
   logic [SIZE_W-1:0] a_cnt_q, f_cnt_q;
   logic [PIDX_W-1:0] f_idx_q;

   logic              ar_valid_q, ar_fail_q;
   logic [ID_W-1:0]   ar_id_q;
   logic [PIDX_W-1:0] ar_idx_q;
   logic [FR_W-1:0]   ar_fr_q;
   logic [SIZE_W-1:0] ar_orig_q, ar_act_q;

   logic              fr_valid_q, fr_fail_q;
   logic [ID_W-1:0]   fr_id_q;
   logic [FR_W-1:0]   fr_fr_q;
   logic [SIZE_W-1:0] fr_orig_q, fr_act_q;

   logic err_q;

   mmu_id_tracker #(
      .ID_W      (ID_W),
      .MAX_OUTST (MAX_OUTST)
   ) u_tracker (
      .clk          (clk),
      .rst          (rst),
      .set_en       (alloc_fire | free_fire),
      .set_id       (next_id_q),
      .set_is_alloc (alloc_fire),
      .query_id     (next_id_q),
      .id_free      (id_free),
      .alloc_chk_en (alloc_rsp_pop),
      .alloc_chk_id (alloc_rsp_id),
      .alloc_hit    (alloc_hit),
      .free_chk_en  (free_rsp_pop),
      .free_chk_id  (free_rsp_id),
      .free_hit     (free_hit),
      .count        (count)
   );

   // Round-robin pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q      <= RR_ALLOC;
         next_id_q <= '0;
      end else begin
         rr_q      <= rr_d;
         next_id_q <= next_id_d;
      end
   end

   // Issue arbitration: grant follows the lone valid, else the pointer; readies are
   // combinational and a stalled ID blocks both channels so IDs are never skipped.
   always_comb begin
      rr_d        = rr_q;
      next_id_d   = next_id_q;
      if (host_alloc_valid != host_free_valid) begin
         grant_alloc = host_alloc_valid;
      end else begin
         grant_alloc = (rr_q == RR_ALLOC);
      end
      grant_free  = ~grant_alloc;
      can_issue   = id_free & (count < CNT_W'(MAX_OUTST));
      host_alloc_ready = ~rst & grant_alloc & ~alloc_req_fifo_almost_full & can_issue;
      host_free_ready  = ~rst & grant_free  & ~free_req_fifo_almost_full  & can_issue;
      alloc_fire  = host_alloc_valid & host_alloc_ready;
      free_fire   = host_free_valid  & host_free_ready;
      if (alloc_fire || free_fire) begin
         rr_d      = (rr_q == RR_ALLOC) ? RR_FREE : RR_ALLOC;
         next_id_d = next_id_q + ID_W'(1);
      end
   end

   assign alloc_rsp_pop = ~rst & ~alloc_rsp_fifo_empty & (~ar_valid_q | host_alloc_rsp_ready);
   assign free_rsp_pop  = ~rst & ~free_rsp_fifo_empty  & (~fr_valid_q | host_free_rsp_ready);

   // Request push registers: one-cycle push carrying the ID consumed at handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_push_q <= 1'b0;
         a_id_q   <= '0;
         a_cnt_q  <= '0;
         f_push_q <= 1'b0;
         f_id_q   <= '0;
         f_idx_q  <= '0;
         f_cnt_q  <= '0;
      end else begin
         a_push_q <= alloc_fire;
         f_push_q <= free_fire;
         if (alloc_fire) begin
            a_id_q  <= next_id_q;
            a_cnt_q <= host_alloc_page_count;
         end
         if (free_fire) begin
            f_id_q  <= next_id_q;
            f_idx_q <= host_free_page_idx;
            f_cnt_q <= host_free_page_count;
         end
      end
   end

   // Response output registers: load on pop, drop valid when the host takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ar_valid_q <= 1'b0;
         ar_id_q    <= '0;
         ar_idx_q   <= '0;
         ar_fail_q  <= 1'b0;
         ar_fr_q    <= '0;
         ar_orig_q  <= '0;
         ar_act_q   <= '0;
         fr_valid_q <= 1'b0;
         fr_id_q    <= '0;
         fr_fail_q  <= 1'b0;
         fr_fr_q    <= '0;
         fr_orig_q  <= '0;
         fr_act_q   <= '0;
      end else begin
         if (alloc_rsp_pop) begin
            ar_valid_q <= 1'b1;
            ar_id_q    <= alloc_rsp_id;
            ar_idx_q   <= alloc_rsp_page_idx;
            ar_fail_q  <= alloc_rsp_fail;
            ar_fr_q    <= alloc_rsp_fail_reason;
            ar_orig_q  <= alloc_rsp_origin_size;
            ar_act_q   <= alloc_rsp_actual_size;
         end else if (host_alloc_rsp_ready) begin
            ar_valid_q <= 1'b0;
         end
         if (free_rsp_pop) begin
            fr_valid_q <= 1'b1;
            fr_id_q    <= free_rsp_id;
            fr_fail_q  <= free_rsp_fail;
            fr_fr_q    <= free_rsp_fail_reason;
            fr_orig_q  <= free_rsp_origin_size;
            fr_act_q   <= free_rsp_actual_size;
         end else if (host_free_rsp_ready) begin
            fr_valid_q <= 1'b0;
         end
      end
   end

   // Sticky flag for responses whose ID is not outstanding on that channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if ((alloc_rsp_pop && !alloc_hit) || (free_rsp_pop && !free_hit)) begin
         err_q <= 1'b1;
      end
   end

   assign alloc_req_push       = a_push_q;
   assign alloc_req_id         = a_id_q;
   assign alloc_req_page_count = a_cnt_q;
   assign free_req_push        = f_push_q;
   assign free_req_id          = f_id_q;
   assign free_req_page_idx    = f_idx_q;
   assign free_req_page_count  = f_cnt_q;

   assign host_alloc_rsp_valid       = ar_valid_q;
   assign host_alloc_rsp_id          = ar_id_q;
   assign host_alloc_rsp_page_idx    = ar_idx_q;
   assign host_alloc_rsp_fail        = ar_fail_q;
   assign host_alloc_rsp_fail_reason = ar_fr_q;
   assign host_alloc_rsp_origin_size = ar_orig_q;
   assign host_alloc_rsp_actual_size = ar_act_q;

   assign host_free_rsp_valid       = fr_valid_q;
   assign host_free_rsp_id          = fr_id_q;
   assign host_free_rsp_fail        = fr_fail_q;
   assign host_free_rsp_fail_reason = fr_fr_q;
   assign host_free_rsp_origin_size = fr_orig_q;
   assign host_free_rsp_actual_size = fr_act_q;

   assign outstanding_count  = count;
   assign err_unexpected_rsp = err_q;

endmodule

// File: tb/tb_mmu_req_agent.sv
// Directed bench for mmu_req_agent: issue, arbitration, backpressure, limits, errors.
module tb_mmu_req_agent;
   import mmu_req_agent_pkg::*;

   localparam int unsigned ID_W   = REQ_ID_WIDTH;
   localparam int unsigned SIZE_W = REQ_SIZE_TYPE_WIDTH;
   localparam int unsigned PIDX_W = ALL_PAGE_IDX_WIDTH;
   localparam int unsigned FR_W   = FAIL_REASON_WIDTH;
   localparam int unsigned CNT_W  = $clog2(MMU_MAX_OUTSTANDING + 1);

   logic clk, rst;
   logic host_alloc_valid, host_alloc_ready;
   logic [SIZE_W-1:0] host_alloc_page_count;
   logic host_free_valid, host_free_ready;
   logic [PIDX_W-1:0] host_free_page_idx;
   logic [SIZE_W-1:0] host_free_page_count;
   logic alloc_req_push;
   logic [ID_W-1:0] alloc_req_id;
   logic [SIZE_W-1:0] alloc_req_page_count;
   logic alloc_req_fifo_almost_full;
   logic free_req_push;
   logic [ID_W-1:0] free_req_id;
   logic [PIDX_W-1:0] free_req_page_idx;
   logic [SIZE_W-1:0] free_req_page_count;
   logic free_req_fifo_almost_full;
   logic alloc_rsp_pop, alloc_rsp_fifo_empty;
   logic [ID_W-1:0] alloc_rsp_id;
   logic [PIDX_W-1:0] alloc_rsp_page_idx;
   logic alloc_rsp_fail;
   logic [FR_W-1:0] alloc_rsp_fail_reason;
   logic [SIZE_W-1:0] alloc_rsp_origin_size, alloc_rsp_actual_size;
   logic free_rsp_pop, free_rsp_fifo_empty;
   logic [ID_W-1:0] free_rsp_id;
   logic free_rsp_fail;
   logic [FR_W-1:0] free_rsp_fail_reason;
   logic [SIZE_W-1:0] free_rsp_origin_size, free_rsp_actual_size;
   logic host_alloc_rsp_valid, host_alloc_rsp_ready;
   logic [ID_W-1:0] host_alloc_rsp_id;
   logic [PIDX_W-1:0] host_alloc_rsp_page_idx;
   logic host_alloc_rsp_fail;
   logic [FR_W-1:0] host_alloc_rsp_fail_reason;
   logic [SIZE_W-1:0] host_alloc_rsp_origin_size, host_alloc_rsp_actual_size;
   logic host_free_rsp_valid, host_free_rsp_ready;
   logic [ID_W-1:0] host_free_rsp_id;
   logic host_free_rsp_fail;
   logic [FR_W-1:0] host_free_rsp_fail_reason;
   logic [SIZE_W-1:0] host_free_rsp_origin_size, host_free_rsp_actual_size;
   logic [CNT_W-1:0] outstanding_count;
   logic err_unexpected_rsp;

   int tests = 0;
   int fails = 0;
   int n_apush = 0, n_fpush = 0, n_apop = 0, n_fpop = 0;

   mmu_req_agent dut (
      .clk                        (clk),
      .rst                        (rst),
      .host_alloc_valid           (host_alloc_valid),
      .host_alloc_ready           (host_alloc_ready),
      .host_alloc_page_count      (host_alloc_page_count),
      .host_free_valid            (host_free_valid),
      .host_free_ready            (host_free_ready),
      .host_free_page_idx         (host_free_page_idx),
      .host_free_page_count       (host_free_page_count),
      .alloc_req_push             (alloc_req_push),
      .alloc_req_id               (alloc_req_id),
      .alloc_req_page_count       (alloc_req_page_count),
      .alloc_req_fifo_almost_full (alloc_req_fifo_almost_full),
      .free_req_push              (free_req_push),
      .free_req_id                (free_req_id),
      .free_req_page_idx          (free_req_page_idx),
      .free_req_page_count        (free_req_page_count),
      .free_req_fifo_almost_full  (free_req_fifo_almost_full),
      .alloc_rsp_pop              (alloc_rsp_pop),
      .alloc_rsp_fifo_empty       (alloc_rsp_fifo_empty),
      .alloc_rsp_id               (alloc_rsp_id),
      .alloc_rsp_page_idx         (alloc_rsp_page_idx),
      .alloc_rsp_fail             (alloc_rsp_fail),
      .alloc_rsp_fail_reason      (alloc_rsp_fail_reason),
      .alloc_rsp_origin_size      (alloc_rsp_origin_size),
      .alloc_rsp_actual_size      (alloc_rsp_actual_size),
      .free_rsp_pop               (free_rsp_pop),
      .free_rsp_fifo_empty        (free_rsp_fifo_empty),
      .free_rsp_id                (free_rsp_id),
      .free_rsp_fail              (free_rsp_fail),
      .free_rsp_fail_reason       (free_rsp_fail_reason),
      .free_rsp_origin_size       (free_rsp_origin_size),
      .free_rsp_actual_size       (free_rsp_actual_size),
      .host_alloc_rsp_valid       (host_alloc_rsp_valid),
      .host_alloc_rsp_ready       (host_alloc_rsp_ready),
      .host_alloc_rsp_id          (host_alloc_rsp_id),
      .host_alloc_rsp_page_idx    (host_alloc_rsp_page_idx),
      .host_alloc_rsp_fail        (host_alloc_rsp_fail),
      .host_alloc_rsp_fail_reason (host_alloc_rsp_fail_reason),
      .host_alloc_rsp_origin_size (host_alloc_rsp_origin_size),
      .host_alloc_rsp_actual_size (host_alloc_rsp_actual_size),
      .host_free_rsp_valid        (host_free_rsp_valid),
      .host_free_rsp_ready        (host_free_rsp_ready),
      .host_free_rsp_id           (host_free_rsp_id),
      .host_free_rsp_fail         (host_free_rsp_fail),
      .host_free_rsp_fail_reason  (host_free_rsp_fail_reason),
      .host_free_rsp_origin_size  (host_free_rsp_origin_size),
      .host_free_rsp_actual_size  (host_free_rsp_actual_size),
      .outstanding_count          (outstanding_count),
      .err_unexpected_rsp         (err_unexpected_rsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mid-cycle event counters for pushes and pops.
   always @(negedge clk) begin
      if (alloc_req_push) n_apush++;
      if (free_req_push)  n_fpush++;
      if (alloc_rsp_pop)  n_apop++;
      if (free_rsp_pop)   n_fpop++;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_idle();
      host_alloc_valid = 1'b0;
      host_alloc_page_count = '0;
      host_free_valid = 1'b0;
      host_free_page_idx = '0;
      host_free_page_count = '0;
      alloc_req_fifo_almost_full = 1'b0;
      free_req_fifo_almost_full = 1'b0;
      alloc_rsp_fifo_empty = 1'b1;
      alloc_rsp_id = '0;
      alloc_rsp_page_idx = '0;
      alloc_rsp_fail = 1'b0;
      alloc_rsp_fail_reason = '0;
      alloc_rsp_origin_size = '0;
      alloc_rsp_actual_size = '0;
      free_rsp_fifo_empty = 1'b1;
      free_rsp_id = '0;
      free_rsp_fail = 1'b0;
      free_rsp_fail_reason = '0;
      free_rsp_origin_size = '0;
      free_rsp_actual_size = '0;
      host_alloc_rsp_ready = 1'b0;
      host_free_rsp_ready = 1'b0;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1'b1;
      tick();
      host_alloc_valid = 1'b1;
      alloc_rsp_fifo_empty = 1'b0;
      #1;
      tests++;
      if (host_alloc_ready !== 1'b0 || host_free_ready !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready: got %0b/%0b want 0/0", host_alloc_ready, host_free_ready);
      end
      tests++;
      if (alloc_rsp_pop !== 1'b0 || alloc_req_push !== 1'b0 || free_req_push !== 1'b0) begin
         fails++;
         $display("FAIL reset_pop_push: got %0b%0b%0b want 000", alloc_rsp_pop, alloc_req_push, free_req_push);
      end
      tests++;
      if (outstanding_count !== '0 || err_unexpected_rsp !== 1'b0 ||
          host_alloc_rsp_valid !== 1'b0 || host_free_rsp_valid !== 1'b0 || alloc_req_id !== '0) begin
         fails++;
         $display("FAIL reset_state: cnt=%0d err=%0b av=%0b fv=%0b id=%0d want all 0",
                  outstanding_count, err_unexpected_rsp, host_alloc_rsp_valid, host_free_rsp_valid, alloc_req_id);
      end
      set_idle();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_alloc();
      do_reset();
      host_alloc_valid = 1'b1;
      host_alloc_page_count = 8'd4;
      #1;
      tests++;
      if (host_alloc_ready !== 1'b1) begin
         fails++;
         $display("FAIL single_ready: got %0b want 1", host_alloc_ready);
      end
      tick();
      host_alloc_valid = 1'b0;
      tests++;
      if (alloc_req_push !== 1'b1 || alloc_req_id !== 8'd0 || alloc_req_page_count !== 8'd4) begin
         fails++;
         $display("FAIL single_push: push=%0b id=%0d cnt=%0d want 1/0/4", alloc_req_push, alloc_req_id, alloc_req_page_count);
      end
      tests++;
      if (outstanding_count !== 7'd1) begin
         fails++;
         $display("FAIL single_count_up: got %0d want 1", outstanding_count);
      end
      tick();
      tests++;
      if (alloc_req_push !== 1'b0) begin
         fails++;
         $display("FAIL single_push_len: got %0b want 0", alloc_req_push);
      end
      alloc_rsp_fifo_empty = 1'b0;
      alloc_rsp_id = 8'd0;
      alloc_rsp_page_idx = 10'd16;
      alloc_rsp_origin_size = 8'd4;
      alloc_rsp_actual_size = 8'd4;
      #1;
      tests++;
      if (alloc_rsp_pop !== 1'b1) begin
         fails++;
         $display("FAIL single_pop: got %0b want 1", alloc_rsp_pop);
      end
      tick();
      alloc_rsp_fifo_empty = 1'b1;
      tests++;
      if (host_alloc_rsp_valid !== 1'b1 || host_alloc_rsp_id !== 8'd0 || host_alloc_rsp_page_idx !== 10'd16 ||
          host_alloc_rsp_actual_size !== 8'd4) begin
         fails++;
         $display("FAIL single_rsp: v=%0b id=%0d idx=%0d act=%0d want 1/0/16/4", host_alloc_rsp_valid,
                  host_alloc_rsp_id, host_alloc_rsp_page_idx, host_alloc_rsp_actual_size);
      end
      tests++;
      if (outstanding_count !== 7'd0 || err_unexpected_rsp !== 1'b0) begin
         fails++;
         $display("FAIL single_retire: cnt=%0d err=%0b want 0/0", outstanding_count, err_unexpected_rsp);
      end
      host_alloc_rsp_ready = 1'b1;
      tick();
      tests++;
      if (host_alloc_rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL single_rsp_drop: got %0b want 0", host_alloc_rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      int a0, f0;
      do_reset();
      host_alloc_valid = 1'b1;
      host_alloc_page_count = 8'd1;
      host_free_valid = 1'b1;
      host_free_page_idx = 10'd5;
      host_free_page_count = 8'd2;
      #1;
      tests++;
      if (host_alloc_ready !== 1'b1 || host_free_ready !== 1'b0) begin
         fails++;
         $display("FAIL rr_first_grant: got %0b/%0b want 1/0", host_alloc_ready, host_free_ready);
      end
      a0 = n_apush;
      f0 = n_fpush;
      for (int k = 0; k < 4; k++) begin
         tick();
         tests++;
         if ((k % 2) == 0) begin
            if (alloc_req_push !== 1'b1 || free_req_push !== 1'b0 || alloc_req_id !== ID_W'(k)) begin
               fails++;
               $display("FAIL rr_alloc_%0d: push=%0b/%0b id=%0d want 1/0/%0d", k, alloc_req_push, free_req_push, alloc_req_id, k);
            end
         end else begin
            if (free_req_push !== 1'b1 || alloc_req_push !== 1'b0 || free_req_id !== ID_W'(k) ||
                free_req_page_idx !== 10'd5) begin
               fails++;
               $display("FAIL rr_free_%0d: push=%0b/%0b id=%0d idx=%0d want 1/0/%0d/5", k, free_req_push,
                        alloc_req_push, free_req_id, free_req_page_idx, k);
            end
         end
      end
      host_alloc_valid = 1'b0;
      host_free_valid = 1'b0;
      tick();
      tests++;
      if (n_apush - a0 != 2 || n_fpush - f0 != 2 || outstanding_count !== 7'd4) begin
         fails++;
         $display("FAIL rr_counts: apush=%0d fpush=%0d cnt=%0d want 2/2/4", n_apush - a0, n_fpush - f0, outstanding_count);
      end
   endtask

   task automatic test_almost_full();
      do_reset();
      host_alloc_valid = 1'b1;
      host_alloc_page_count = 8'd3;
      alloc_req_fifo_almost_full = 1'b1;
      #1;
      tests++;
      if (host_alloc_ready !== 1'b0) begin
         fails++;
         $display("FAIL af_ready: got %0b want 0", host_alloc_ready);
      end
      tick();
      tests++;
      if (alloc_req_push !== 1'b0) begin
         fails++;
         $display("FAIL af_no_push: got %0b want 0", alloc_req_push);
      end
      alloc_req_fifo_almost_full = 1'b0;
      #1;
      tests++;
      if (host_alloc_ready !== 1'b1) begin
         fails++;
         $display("FAIL af_resume_ready: got %0b want 1", host_alloc_ready);
      end
      tick();
      host_alloc_valid = 1'b0;
      tests++;
      if (alloc_req_push !== 1'b1 || alloc_req_id !== 8'd0) begin
         fails++;
         $display("FAIL af_resume_push: push=%0b id=%0d want 1/0", alloc_req_push, alloc_req_id);
      end
   endtask

   task automatic test_outstanding_limit();
      do_reset();
      host_alloc_valid = 1'b1;
      host_alloc_page_count = 8'd1;
      for (int k = 0; k < 64; k++) tick();
      #1;
      tests++;
      if (outstanding_count !== 7'd64 || host_alloc_ready !== 1'b0) begin
         fails++;
         $display("FAIL limit_stall: cnt=%0d ready=%0b want 64/0", outstanding_count, host_alloc_ready);
      end
      tick();
      tests++;
      if (alloc_req_push !== 1'b0) begin
         fails++;
         $display("FAIL limit_no_push: got %0b want 0", alloc_req_push);
      end
      alloc_rsp_fifo_empty = 1'b0;
      alloc_rsp_id = 8'd5;
      tick();
      alloc_rsp_fifo_empty = 1'b1;
      #1;
      tests++;
      if (outstanding_count !== 7'd63 || host_alloc_ready !== 1'b1) begin
         fails++;
         $display("FAIL limit_release: cnt=%0d ready=%0b want 63/1", outstanding_count, host_alloc_ready);
      end
      tick();
      host_alloc_valid = 1'b0;
      tests++;
      if (alloc_req_push !== 1'b1 || alloc_req_id !== 8'd64 || outstanding_count !== 7'd64) begin
         fails++;
         $display("FAIL limit_next_id: push=%0b id=%0d cnt=%0d want 1/64/64", alloc_req_push, alloc_req_id, outstanding_count);
      end
   endtask

   task automatic test_unexpected();
      do_reset();
      free_rsp_fifo_empty = 1'b0;
      free_rsp_id = 8'd9;
      free_rsp_fail = 1'b1;
      free_rsp_fail_reason = 3'd2;
      tick();
      free_rsp_fifo_empty = 1'b1;
      tests++;
      if (err_unexpected_rsp !== 1'b1 || host_free_rsp_valid !== 1'b1 || host_free_rsp_id !== 8'd9 ||
          host_free_rsp_fail_reason !== 3'd2 || outstanding_count !== 7'd0) begin
         fails++;
         $display("FAIL unexp_free: err=%0b v=%0b id=%0d fr=%0d cnt=%0d want 1/1/9/2/0", err_unexpected_rsp,
                  host_free_rsp_valid, host_free_rsp_id, host_free_rsp_fail_reason, outstanding_count);
      end
      do_reset();
      host_free_valid = 1'b1;
      host_free_page_idx = 10'd7;
      host_free_page_count = 8'd1;
      tick();
      host_free_valid = 1'b0;
      alloc_rsp_fifo_empty = 1'b0;
      alloc_rsp_id = 8'd0;
      tick();
      alloc_rsp_fifo_empty = 1'b1;
      tests++;
      if (err_unexpected_rsp !== 1'b1 || outstanding_count !== 7'd1 || host_alloc_rsp_valid !== 1'b1) begin
         fails++;
         $display("FAIL unexp_type: err=%0b cnt=%0d v=%0b want 1/1/1", err_unexpected_rsp, outstanding_count, host_alloc_rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      int a0, f0;
      do_reset();
      alloc_rsp_fifo_empty = 1'b0;
      alloc_rsp_id = 8'd1;
      free_rsp_fifo_empty = 1'b0;
      free_rsp_id = 8'd2;
      a0 = n_apop;
      f0 = n_fpop;
      for (int k = 0; k < 4; k++) tick();
      tests++;
      if (n_apop - a0 != 1 || n_fpop - f0 != 1 || host_alloc_rsp_valid !== 1'b1 || host_free_rsp_valid !== 1'b1) begin
         fails++;
         $display("FAIL bp_hold: apop=%0d fpop=%0d av=%0b fv=%0b want 1/1/1/1", n_apop - a0, n_fpop - f0,
                  host_alloc_rsp_valid, host_free_rsp_valid);
      end
      host_alloc_rsp_ready = 1'b1;
      host_free_rsp_ready = 1'b1;
      a0 = n_apop;
      f0 = n_fpop;
      for (int k = 0; k < 3; k++) tick();
      tests++;
      if (n_apop - a0 != 3 || n_fpop - f0 != 3) begin
         fails++;
         $display("FAIL bp_stream: apop=%0d fpop=%0d want 3/3", n_apop - a0, n_fpop - f0);
      end
      tests++;
      if (err_unexpected_rsp !== 1'b1) begin
         fails++;
         $display("FAIL bp_err_set: got %0b want 1", err_unexpected_rsp);
      end
      rst = 1'b1;
      #1;
      tests++;
      if (host_alloc_rsp_valid !== 1'b0 || host_free_rsp_valid !== 1'b0 || alloc_rsp_pop !== 1'b0 ||
          free_rsp_pop !== 1'b0 || outstanding_count !== '0 || err_unexpected_rsp !== 1'b0 ||
          host_alloc_rsp_id !== '0) begin
         fails++;
         $display("FAIL bp_reset: av=%0b fv=%0b ap=%0b fp=%0b cnt=%0d err=%0b id=%0d want all 0", host_alloc_rsp_valid,
                  host_free_rsp_valid, alloc_rsp_pop, free_rsp_pop, outstanding_count, err_unexpected_rsp, host_alloc_rsp_id);
      end
      tick();
      set_idle();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      test_reset();
      test_single_alloc();
      test_round_robin();
      test_almost_full();
      test_outstanding_limit();
      test_unexpected();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
